// File: rtl/bool_sweep_engine.sv
// Exhaustive sweep engine: walks all 2^N input vectors of a loadable truth
// table in ascending order, one registered result per cycle, and counts the ones.
module bool_sweep_engine #(
  parameter int                 N        = 4,
  parameter logic [(1<<N)-1:0]  TT_RESET = 16'h8AAA
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tt_load,
  input  logic [(1<<N)-1:0]   tt_in,
  input  logic                start,
  input  logic                pause,
  output logic [N-1:0]        vec_out,
  output logic                f_out,
  output logic                valid,
  output logic [N:0]          ones_cnt,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [N-1:0] LAST_IDX = {N{1'b1}};
  localparam logic [N-1:0] IDX_ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [N-1:0]      idx;
  logic [(1<<N)-1:0] tt;

  // NOTE: all state here updates with non-blocking assignments so every
  // register samples the values from before the edge, regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      // NOTE: the truth table is a flat register, not a RAM, so it can and
      // must take its reset value here; a reset mid-sweep discards any load.
      tt       <= TT_RESET;
      vec_out  <= '0;
      f_out    <= 1'b0;
      valid    <= 1'b0;
      ones_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      valid <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          // A simultaneous load and start sweeps the freshly loaded table.
          if (tt_load) tt <= tt_in;
          if (start) begin
            state    <= SWEEP;
            idx      <= '0;
            ones_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        SWEEP: begin
          if (!pause) begin
            vec_out  <= idx;
            f_out    <= tt[idx];
            valid    <= 1'b1;
            ones_cnt <= ones_cnt + {{N{1'b0}}, tt[idx]};
            idx      <= idx + IDX_ONE;
            if (idx == LAST_IDX) state <= DONE;
          end
        end
        DONE: begin
          // vec_out, f_out and ones_cnt keep the final result until restart.
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bool_sweep_engine.sv
// Bench for bool_sweep_engine: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_bool_sweep_engine;

  localparam int N = 4;
  localparam logic [15:0] TT_DEF = 16'h8AAA;

  logic        clk = 1'b0;
  logic        rst, tt_load, start, pause;
  logic [15:0] tt_in;
  logic [3:0]  vec_out;
  logic        f_out, valid, busy, done;
  logic [4:0]  ones_cnt;

  logic        tt_load2, start2, pause2;
  logic [3:0]  tt_in2;
  logic [1:0]  vec_out2;
  logic        f_out2, valid2, busy2, done2;
  logic [2:0]  ones_cnt2;

  bool_sweep_engine #(.N(N), .TT_RESET(TT_DEF)) dut (
    .clk(clk), .rst(rst), .tt_load(tt_load), .tt_in(tt_in), .start(start),
    .pause(pause), .vec_out(vec_out), .f_out(f_out), .valid(valid),
    .ones_cnt(ones_cnt), .busy(busy), .done(done)
  );

  bool_sweep_engine #(.N(2), .TT_RESET(4'b1000)) dut2 (
    .clk(clk), .rst(rst), .tt_load(tt_load2), .tt_in(tt_in2), .start(start2),
    .pause(pause2), .vec_out(vec_out2), .f_out(f_out2), .valid(valid2),
    .ones_cnt(ones_cnt2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a sweep is a queue of pending vectors; one is consumed
  // per unpaused cycle, and the cycle after the queue empties reports done.
  logic [15:0] m_tt;
  int          q[$];
  bit          m_init = 0, finishing = 0;
  int          exp_vec = 0, exp_cnt = 0;
  bit          exp_f = 0, exp_valid = 0, exp_busy = 0, exp_done = 0;

  initial begin
    bit s_rst, s_start, s_load, s_pause;
    logic [15:0] s_tt;
    int v;
    forever begin
      @(posedge clk);
      s_rst = rst; s_start = start; s_load = tt_load; s_pause = pause; s_tt = tt_in;
      #1;
      if (s_rst) begin
        m_tt = TT_DEF; q.delete(); finishing = 0; m_init = 1;
        exp_vec = 0; exp_f = 0; exp_valid = 0; exp_cnt = 0; exp_busy = 0; exp_done = 0;
      end else if (m_init) begin
        exp_valid = 0;
        exp_done  = 0;
        if (finishing) begin
          exp_done = 1; exp_busy = 0; finishing = 0;
        end else if (q.size() != 0) begin
          if (!s_pause) begin
            v = q.pop_front();
            exp_vec = v; exp_f = m_tt[v]; exp_cnt += int'(m_tt[v]); exp_valid = 1;
            if (q.size() == 0) finishing = 1;
          end
        end else begin
          if (s_load) m_tt = s_tt;
          if (s_start) begin
            for (int i = 0; i < 16; i++) q.push_back(i);
            exp_cnt = 0; exp_busy = 1;
          end
        end
      end
      if (m_init) begin
        check("valid", valid, exp_valid);
        check("done", done, exp_done);
        check("busy", busy, exp_busy);
        check("ones_cnt", ones_cnt, exp_cnt);
        check("vec_out", vec_out, exp_vec);
        check("f_out", f_out, exp_f);
      end
    end
  end

  // Start a sweep and collect results until done; optional pauses after the
  // results for vectors p1/p2, and an ignored start+load poke after vector poke.
  task automatic run_sweep(input int p1, input int p1len, input int p2, input int poke,
                           output int nval, output logic [15:0] fb);
    int  pc;
    int  held;
    bit  got_done;
    nval = 0; fb = '0; pc = 0; held = 0; got_done = 0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      tt_load = 1'b0;
      if (pc > 0) begin
        check("pause_valid", valid, 0);
        check("pause_hold_vec", vec_out, held);
        pc--;
        if (pc == 0) pause = 1'b0;
      end else if (valid) begin
        nval++;
        fb[vec_out] = f_out;
        if (int'(vec_out) == p1) begin pause = 1'b1; pc = p1len; held = p1; end
        if (int'(vec_out) == p2) begin pause = 1'b1; pc = 2;     held = p2; end
        if (int'(vec_out) == poke) begin start = 1'b1; tt_load = 1'b1; tt_in = 16'hFFFF; end
      end
      if (done) got_done = 1;
    end
    if (!got_done) check("sweep_timeout", 0, 1);
  endtask

  initial begin
    int          nv;
    logic [15:0] fb;
    bit          hit;
    rst = 1'b1; tt_load = 1'b0; start = 1'b0; pause = 1'b0; tt_in = '0;
    tt_load2 = 1'b0; start2 = 1'b0; pause2 = 1'b0; tt_in2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_valid", valid, 0);
    check("reset_ones", ones_cnt, 0);

    // Default table: f = 0,1,0,1,0,1,0,1,0,1,0,1,0,0,0,1
    run_sweep(-1, 0, -1, -1, nv, fb);
    check("t1_fbits", fb, 16'h8AAA);
    check("t1_nvalid", nv, 16);
    check("t1_ones", ones_cnt, 7);
    check("t1_busy_at_done", busy, 0);

    @(negedge clk); tt_load = 1'b1; tt_in = 16'hFFFF;
    @(negedge clk); tt_load = 1'b0;
    run_sweep(-1, 0, -1, -1, nv, fb);
    check("t2_fbits", fb, 16'hFFFF);
    check("t2_ones", ones_cnt, 5'b10000);

    @(negedge clk); tt_load = 1'b1; tt_in = 16'h0000;
    @(negedge clk); tt_load = 1'b0;
    run_sweep(-1, 0, -1, -1, nv, fb);
    check("t2_zero_ones", ones_cnt, 0);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    run_sweep(4, 3, 14, -1, nv, fb);
    check("t3_nvalid", nv, 16);
    check("t3_ones", ones_cnt, 7);
    @(negedge clk);
    check("t3_vec_hold", vec_out, 15);

    run_sweep(-1, 0, -1, 6, nv, fb);
    check("t4_nvalid", nv, 16);
    check("t4_ones", ones_cnt, 7);
    repeat (3) @(negedge clk);
    check("t4_no_restart", busy, 0);

    // Load all-ones, then reset mid-sweep: the loaded table must be lost.
    @(negedge clk); tt_load = 1'b1; tt_in = 16'hFFFF; start = 1'b1;
    hit = 0;
    for (int cyc = 0; cyc < 60 && !hit; cyc++) begin
      @(negedge clk);
      tt_load = 1'b0; start = 1'b0;
      if (valid && vec_out == 4'd9) hit = 1;
    end
    if (!hit) check("t5_timeout", 0, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_valid", valid, 0);
    check("t5_ones", ones_cnt, 0);
    run_sweep(-1, 0, -1, -1, nv, fb);
    check("t5_fbits", fb, 16'h8AAA);
    check("t5_ones_after", ones_cnt, 7);

    // N=2 AND table: valid after E1..E4, done after E5.
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    check("n2_busy", busy2, 1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("n2_valid", valid2, (k >= 1 && k <= 4));
      check("n2_done", done2, (k == 5));
      if (k <= 4) begin
        check("n2_vec", vec_out2, k - 1);
        check("n2_f", f_out2, (k == 4));
      end
      if (k == 5) begin
        check("n2_ones", ones_cnt2, 1);
        check("n2_busy_done", busy2, 0);
      end
    end

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 7) == 0);
      tt_load = ($urandom_range(0, 5) == 0);
      tt_in   = 16'($urandom);
      pause   = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; tt_load = 1'b0; pause = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
